// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory request/response, redirect
// from execute, and the decode-side instruction handshake.
interface fetch_prefetch_queue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [XLEN-1:0]   imem_rsp_data;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              ins_valid;
    logic              ins_ready;
    logic [XLEN-1:0]   ins_out;
    logic [XLEN-1:0]   ins_pc;
    logic [XLEN-1:0]   ins_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr, ins_valid, ins_out, ins_pc, ins_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, ins_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, ins_valid, ins_out, ins_pc, ins_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues pipelined in-order fetches, buffers up to
// DEPTH PC-tagged instructions for decode, and flushes on branch redirect.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                    clk,
    input logic                    rst,
    fetch_prefetch_queue_if.master fq
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] ptr_t;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];
    ptr_t            head, tail, fill, drop;
    logic [XLEN-1:0] fetch_pc;

    ptr_t            count, unfilled;
    logic [PW+1:0]   occ;
    logic            req_fire, rsp_keep, pop;
    logic [XLEN-1:0] head_pc;

    // head..fill holds returned words; fill..tail still awaits its response.
    assign count    = tail - head;
    assign unfilled = tail - fill;
    assign occ      = {1'b0, count} + {1'b0, drop};

    assign fq.imem_req_valid = rst && !fq.redirect && (occ < (PW+2)'(DEPTH));
    assign req_fire          = fq.imem_req_valid && fq.imem_req_ready;
    assign rsp_keep          = fq.imem_rsp_valid && !fq.redirect && (drop == '0);
    assign fq.ins_valid      = rst && (fill != head);
    assign pop               = fq.ins_valid && fq.ins_ready;

    // Outputs are gated so they read 0 for as long as reset is held.
    assign head_pc          = pc_mem[head[PW-1:0]];
    assign fq.imem_req_addr = rst ? fetch_pc[ADDR_W-1:0] : '0;
    assign fq.ins_out       = rst ? ins_mem[head[PW-1:0]] : '0;
    assign fq.ins_pc        = rst ? head_pc : '0;
    assign fq.ins_pc_plus4  = rst ? head_pc + XLEN'(4) : '0;

    always_ff @(posedge clk) begin
        if (req_fire) pc_mem[tail[PW-1:0]] <= fetch_pc;
        if (rsp_keep) ins_mem[fill[PW-1:0]] <= fq.imem_rsp_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            drop     <= '0;
            fetch_pc <= RESET_PC;
        end else if (fq.redirect) begin
            head     <= tail;
            fill     <= tail;
            // Each unfilled slot still owes a word; one arriving now settles one of them.
            drop     <= drop + unfilled - ptr_t'(fq.imem_rsp_valid);
            fetch_pc <= {fq.redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop) head <= head + 1'b1;
            if (fq.imem_rsp_valid) begin
                if (drop != '0) drop <= drop - 1'b1;
                else            fill <= fill + 1'b1;
            end
        end
    end

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst)
        fq.imem_rsp_valid |-> (unfilled != '0 || drop != '0));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with configurable latency and
// back-pressure, plus a PC-stream scoreboard derived from fetch/redirect rules.
module tb_fetch_prefetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) fq ();

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fq (fq.master)
    );

    int          n_chk = 0, n_fail = 0, n_pop = 0, n_acc = 0, cyc = 0;
    logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;

    function automatic logic [31:0] mem_word(logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory model: in-order responses, fixed or random latency, optional random ready.
    bit          rnd_lat = 0, rnd_rdy = 0;
    int          fix_lat = 1;
    logic        acc_s = 0, rsp_s = 0;
    logic [7:0]  acc_addr = '0;
    logic [7:0]  pend_addr[$];
    int          pend_due[$];

    always @(negedge clk) begin
        acc_s    = rst && fq.imem_req_valid && fq.imem_req_ready;
        rsp_s    = rst && fq.imem_rsp_valid;
        acc_addr = fq.imem_req_addr;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
            fq.imem_rsp_valid = 1'b0;
            fq.imem_rsp_data  = '0;
            fq.imem_req_ready = 1'b1;
        end else begin
            cyc++;
            if (rsp_s && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (acc_s) begin
                pend_addr.push_back(acc_addr);
                pend_due.push_back(cyc + (rnd_lat ? int'($urandom_range(0, 2)) : fix_lat - 1));
                n_acc++;
            end
            #1;
            fq.imem_req_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                fq.imem_rsp_valid = 1'b1;
                fq.imem_rsp_data  = mem_word(pend_addr[0]);
            end else begin
                fq.imem_rsp_valid = 1'b0;
            end
        end
    end

    // One clock: scoreboard at negedge, model update at posedge, return at posedge+2.
    task automatic tick();
        logic        pop, acc, rd;
        logic [31:0] rpc;
        @(negedge clk);
        if (rst) begin
            if (fq.ins_valid) begin
                chk("sb_pc", fq.ins_pc, exp_pc);
                chk("sb_ins", fq.ins_out, mem_word(exp_pc[7:0]));
                chk("sb_pc4", fq.ins_pc_plus4, exp_pc + 32'd4);
            end
            if (fq.redirect) chk("req_during_redirect", 32'(fq.imem_req_valid), 32'd0);
            else if (fq.imem_req_valid) chk("req_addr", 32'(fq.imem_req_addr), 32'(exp_req[7:0]));
        end
        pop = rst && fq.ins_valid && fq.ins_ready;
        acc = rst && fq.imem_req_valid && fq.imem_req_ready;
        rd  = fq.redirect;
        rpc = fq.redirect_pc;
        @(posedge clk);
        if (!rst) begin
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else if (rd) begin
            exp_pc  = rpc & ~32'd3;
            exp_req = rpc & ~32'd3;
        end else begin
            if (pop) begin
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
            if (acc) exp_req = exp_req + 32'd4;
        end
        #2;
    endtask

    task automatic wait_valid(string tag);
        int n = 0;
        while (!fq.ins_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_wait_valid"}, 32'(fq.ins_valid), 32'd1);
    endtask

    task automatic redirect_to(logic [31:0] pc);
        fq.redirect    = 1'b1;
        fq.redirect_pc = pc;
        #1;
        tick();
        fq.redirect = 1'b0;
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_req_valid"}, 32'(fq.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, 32'(fq.imem_req_addr), 32'd0);
        chk({tag, "_ins_valid"}, 32'(fq.ins_valid), 32'd0);
        chk({tag, "_ins_out"}, fq.ins_out, 32'd0);
        chk({tag, "_ins_pc"}, fq.ins_pc, 32'd0);
        chk({tag, "_ins_pc4"}, fq.ins_pc_plus4, 32'd0);
    endtask

    initial begin
        int a0, p0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        fq.ins_ready   = 1'b0;
        repeat (3) tick();
        chk_zero("reset");

        // Release: first instruction two cycles later, then one per cycle.
        fq.ins_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t1_c0_req_valid", 32'(fq.imem_req_valid), 32'd1);
        chk("t1_c0_req_addr", 32'(fq.imem_req_addr), RESET_PC);
        chk("t1_c0_ins_valid", 32'(fq.ins_valid), 32'd0);
        tick();
        chk("t1_c1_ins_valid", 32'(fq.ins_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_valid", 32'(fq.ins_valid), 32'd1);
            chk("t1_pc", fq.ins_pc, 32'(i * 4));
        end

        // Redirect + pop + response all in one cycle.
        tick();
        tick();
        chk("t5_pre_valid", 32'(fq.ins_valid), 32'd1);
        fq.redirect    = 1'b1;
        fq.redirect_pc = 32'h80;
        #1;
        chk("t5_no_req_on_redirect", 32'(fq.imem_req_valid), 32'd0);
        tick();
        fq.redirect = 1'b0;
        #1;
        chk("t5_valid_after", 32'(fq.ins_valid), 32'd0);
        chk("t5_req_valid", 32'(fq.imem_req_valid), 32'd1);
        chk("t5_req_addr", 32'(fq.imem_req_addr), 32'h80);
        wait_valid("t5");
        chk("t5_pc", fq.ins_pc, 32'h80);

        // Unaligned redirect target.
        redirect_to(32'h43);
        chk("t4_req_addr", 32'(fq.imem_req_addr), 32'h40);
        wait_valid("t4");
        chk("t4_pc", fq.ins_pc, 32'h40);
        chk("t4_pc4", fq.ins_pc_plus4, 32'h44);

        // PC wrap at 2^XLEN.
        redirect_to(32'hFFFF_FFFE);
        wait_valid("t6");
        chk("t6_pc", fq.ins_pc, 32'hFFFF_FFFC);
        chk("t6_pc4", fq.ins_pc_plus4, 32'h0);
        tick();
        chk("t6_next_valid", 32'(fq.ins_valid), 32'd1);
        chk("t6_next_pc", fq.ins_pc, 32'h0);

        // Slow memory: redirect with several requests in flight.
        fix_lat = 3;
        repeat (8) tick();
        redirect_to(32'h40);
        chk("t3_valid_after", 32'(fq.ins_valid), 32'd0);
        wait_valid("t3");
        chk("t3_pc", fq.ins_pc, 32'h40);
        chk("t3_pc4", fq.ins_pc_plus4, 32'h44);

        // Decode stalled: queue fills to DEPTH, requests stop, head holds.
        rst = 1'b0;
        #1;
        chk_zero("t2_rst");
        tick();
        tick();
        fix_lat      = 1;
        fq.ins_ready = 1'b0;
        rst          = 1'b1;
        a0           = n_acc;
        repeat (10) tick();
        chk("t2_req_count", 32'(n_acc - a0), 32'(DEPTH));
        chk("t2_req_valid", 32'(fq.imem_req_valid), 32'd0);
        chk("t2_ins_valid", 32'(fq.ins_valid), 32'd1);
        chk("t2_pc", fq.ins_pc, RESET_PC);
        chk("t2_ins", fq.ins_out, mem_word(RESET_PC[7:0]));

        // Random back-pressure, latency, decode stalls and redirects.
        rnd_lat = 1;
        rnd_rdy = 1;
        p0      = n_pop;
        for (int i = 0; i < 1500; i++) begin
            fq.ins_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                fq.redirect    = 1'b1;
                fq.redirect_pc = $urandom;
            end else begin
                fq.redirect = 1'b0;
            end
            tick();
        end
        fq.redirect = 1'b0;
        chk("t7_progress", 32'(n_pop - p0 > 200), 32'd1);

        // Reset mid-burst, then restart at RESET_PC.
        fq.ins_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk_zero("t8_rst");
        rnd_lat = 0;
        rnd_rdy = 0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t8_req_valid", 32'(fq.imem_req_valid), 32'd1);
        chk("t8_req_addr", 32'(fq.imem_req_addr), RESET_PC);
        tick();
        tick();
        chk("t8_valid", 32'(fq.ins_valid), 32'd1);
        chk("t8_pc", fq.ins_pc, RESET_PC);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
